// File: rtl/fp_unpack_responder.sv
// Responder that unpacks an IEEE-754 single into sign, unbiased exponent,
// explicit-hidden-bit mantissa and class; denormals normalised one bit per cycle.
module fp_unpack_responder #(
    parameter int EXP_W = 10,
    parameter int BIAS  = 127
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_en,
    input  logic [31:0]      req_data,
    output logic             busy,
    output logic             rsp_valid,
    output logic             rsp_sign,
    output logic [EXP_W-1:0] rsp_exp,
    output logic [23:0]      rsp_mant,
    output logic [1:0]       rsp_class
);

    typedef enum logic [1:0] {IDLE, DECODE, NORM, DONE} state_t;

    localparam logic [1:0] CLS_ZERO   = 2'd0;
    localparam logic [1:0] CLS_NORMAL = 2'd1;
    localparam logic [1:0] CLS_INF    = 2'd2;
    localparam logic [1:0] CLS_NAN    = 2'd3;

    localparam logic [EXP_W-1:0] BIAS_E  = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] DEN_EXP = EXP_W'(1 - BIAS);
    localparam logic [EXP_W-1:0] MAX_EXP = EXP_W'(128);

    state_t state, state_nxt;

    logic [31:0]      data_q;
    logic [EXP_W-1:0] exp_q, exp_nxt;
    logic [23:0]      mant_q, mant_nxt;
    logic [1:0]       cls_q, cls_nxt;
    logic [7:0]       efield;
    logic [22:0]      frac;

    assign efield    = data_q[30:23];
    assign frac      = data_q[22:0];
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == DONE);

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_q;
        mant_nxt  = mant_q;
        cls_nxt   = cls_q;
        case (state)
            IDLE: begin
                if (req_en) state_nxt = DECODE;
            end
            DECODE: begin
                if (efield == 8'h00) begin
                    if (frac == '0) begin
                        mant_nxt  = '0;
                        exp_nxt   = '0;
                        cls_nxt   = CLS_ZERO;
                        state_nxt = DONE;
                    end else begin
                        mant_nxt  = {1'b0, frac};
                        exp_nxt   = DEN_EXP;
                        cls_nxt   = CLS_NORMAL;
                        state_nxt = NORM;
                    end
                end else if (efield == 8'hFF) begin
                    mant_nxt  = {1'b1, frac};
                    exp_nxt   = MAX_EXP;
                    cls_nxt   = (frac == '0) ? CLS_INF : CLS_NAN;
                    state_nxt = DONE;
                end else begin
                    mant_nxt  = {1'b1, frac};
                    exp_nxt   = {{(EXP_W-8){1'b0}}, efield} - BIAS_E;
                    cls_nxt   = CLS_NORMAL;
                    state_nxt = DONE;
                end
            end
            NORM: begin
                // Leave on the shift that sets the leading bit, so L shifts cost L cycles.
                if (mant_q[23]) begin
                    state_nxt = DONE;
                end else begin
                    mant_nxt = mant_q << 1;
                    exp_nxt  = exp_q - 1'b1;
                    if (mant_q[22]) state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            data_q    <= '0;
            exp_q     <= '0;
            mant_q    <= '0;
            cls_q     <= '0;
            rsp_sign  <= 1'b0;
            rsp_exp   <= '0;
            rsp_mant  <= '0;
            rsp_class <= '0;
        end else begin
            state  <= state_nxt;
            exp_q  <= exp_nxt;
            mant_q <= mant_nxt;
            cls_q  <= cls_nxt;
            if (state == IDLE && req_en) data_q <= req_data;
            if (state != DONE && state_nxt == DONE) begin
                rsp_sign  <= data_q[31];
                rsp_exp   <= exp_nxt;
                rsp_mant  <= mant_nxt;
                rsp_class <= cls_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fp_unpack_responder.sv
// Scoreboard bench for fp_unpack_responder: directed requests push expected
// responses; a negedge monitor pops and checks fields and latency.
module tb_fp_unpack_responder;

    logic        clk;
    logic        reset;
    logic        req_en;
    logic [31:0] req_data;
    logic        busy;
    logic        rsp_valid;
    logic        rsp_sign;
    logic [9:0]  rsp_exp;
    logic [23:0] rsp_mant;
    logic [1:0]  rsp_class;

    fp_unpack_responder #(.EXP_W(10), .BIAS(127)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_en    (req_en),
        .req_data  (req_data),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_sign  (rsp_sign),
        .rsp_exp   (rsp_exp),
        .rsp_mant  (rsp_mant),
        .rsp_class (rsp_class)
    );

    typedef struct {
        logic        s;
        logic [9:0]  e;
        logic [23:0] m;
        logic [1:0]  c;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   cyc = 0;
    int   tests = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            last = '{s: 1'b0, e: '0, m: '0, c: '0, acc: 0, lat: 0};
            check("reset_busy", 32'(busy), 0);
            check("reset_valid", 32'(rsp_valid), 0);
            check("reset_fields", {5'd0, rsp_sign, rsp_exp, rsp_mant[13:0], rsp_class}, 0);
            check("reset_mant", 32'(rsp_mant), 0);
        end else if (rsp_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 32'(rsp_valid), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sign", 32'(rsp_sign), 32'(e.s));
                check("exp", 32'(rsp_exp), 32'(e.e));
                check("mant", 32'(rsp_mant), 32'(e.m));
                check("class", 32'(rsp_class), 32'(e.c));
                check("latency", 32'(cyc - e.acc), 32'(1 + e.lat));
                check("busy_in_done", 32'(busy), 1);
                last = e;
            end
        end else begin
            check("hold_sign", 32'(rsp_sign), 32'(last.s));
            check("hold_exp", 32'(rsp_exp), 32'(last.e));
            check("hold_mant", 32'(rsp_mant), 32'(last.m));
            check("hold_class", 32'(rsp_class), 32'(last.c));
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic [9:0] e,
                        input logic [23:0] m, input logic [1:0] c, input int lat);
        wait_idle();
        req_en   = 1'b1;
        req_data = d;
        @(posedge clk);
        #1;
        req_en = 1'b0;
        q.push_back('{s: s, e: e, m: m, c: c, acc: cyc, lat: lat});
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(q.size()), 0);
    endtask

    initial begin
        int a;
        reset    = 1'b0;
        req_en   = 1'b0;
        req_data = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // 1.0, plus busy profile around the accept edge
        send(32'h3F80_0000, 1'b0, 10'h000, 24'h80_0000, 2'd1, 0);
        @(negedge clk); check("busy_decode", 32'(busy), 1);
        @(negedge clk); check("busy_done", 32'(busy), 1);
        @(negedge clk); check("busy_idle", 32'(busy), 0);
        drain();

        // -pi, with req_en pulses during DECODE and DONE that must be ignored
        send(32'hC049_0FDB, 1'b1, 10'h001, 24'hC9_0FDB, 2'd1, 0);
        @(negedge clk); req_en = 1'b1; req_data = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk); req_en = 1'b0;
        repeat (4) @(negedge clk);
        drain();

        send(32'h0000_0001, 1'b0, 10'h36B, 24'h80_0000, 2'd1, 23);
        drain();
        send(32'h0040_0000, 1'b0, 10'h381, 24'h80_0000, 2'd1, 1);
        send(32'h0000_0003, 1'b0, 10'h36C, 24'hC0_0000, 2'd1, 22);
        send(32'h0080_0000, 1'b0, 10'h382, 24'h80_0000, 2'd1, 0);
        send(32'h7F7F_FFFF, 1'b0, 10'h07F, 24'hFF_FFFF, 2'd1, 0);
        send(32'h7F80_0000, 1'b0, 10'h080, 24'h80_0000, 2'd2, 0);
        send(32'h7FC0_0000, 1'b0, 10'h080, 24'hC0_0000, 2'd3, 0);
        send(32'h8000_0000, 1'b1, 10'h000, 24'h00_0000, 2'd0, 0);
        drain();

        // Reset in the middle of normalising: response must be discarded
        send(32'h0000_0001, 1'b0, 10'h36B, 24'h80_0000, 2'd1, 23);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        q.delete();
        #1;
        check("async_busy", 32'(busy), 0);
        check("async_valid", 32'(rsp_valid), 0);
        check("async_exp", 32'(rsp_exp), 0);
        check("async_mant", 32'(rsp_mant), 0);
        check("async_class", 32'(rsp_class), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (30) @(negedge clk);
        send(32'h4000_0000, 1'b0, 10'h001, 24'h80_0000, 2'd1, 0);
        drain();

        // Back-to-back: req_en held high, accepts every third edge
        wait_idle();
        req_en   = 1'b1;
        req_data = 32'h3F80_0000;
        @(posedge clk);
        #1;
        a = cyc;
        for (int k = 0; k < 3; k++)
            q.push_back('{s: 1'b0, e: 10'h000, m: 24'h80_0000, c: 2'd1, acc: a + 3 * k, lat: 0});
        repeat (6) @(posedge clk);
        #1 req_en = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        check("queue_empty", 32'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
